// File: rtl/nas_vid_gen.sv
// ============================================================================
// nas_vid_gen - NASCOM-style character video generator with on-chip video RAM.
// Macro NAS_VID_GEN_INVERSE_EN enables inverse video on RAM bit 7.  Rev 1.0
// ============================================================================
`default_nettype none

module nas_vid_gen #(
   parameter int DOT_W        = 8,
   parameter int H_TOTAL      = 64,
   parameter int H_ACTIVE     = 48,
   parameter int H_SYNC_START = 52,
   parameter int H_SYNC_LEN   = 5,
   parameter int ROW_LINES    = 16,
   parameter int ROWS         = 16,
   parameter int V_TOTAL      = 312,
   parameter int V_SYNC_START = 290,
   parameter int V_SYNC_LEN   = 10,
   parameter int STRIDE_LOG2  = 6,
   parameter int TOP_ROW      = 15,
   parameter int ADDR_W       = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vdusel_n,
   input  logic              wr_n,
   input  logic              rd_n,
   input  logic [ADDR_W-1:0] cpu_a,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic [6:0]        chr_code,
   output logic [3:0]        chr_rs,
   input  logic [DOT_W-1:0]  chr_dots,
   output logic              vid_sync,
   output logic              vid_data,
   output logic              vid_active,
   output logic              frame_start
);

   localparam int DEPTH  = ROWS << STRIDE_LOG2;
   localparam int RAM_AW = $clog2(DEPTH);
   localparam int DW     = $clog2(DOT_W);
   localparam int HW     = $clog2(H_TOTAL + 1);
   localparam int VW     = $clog2(V_TOTAL + 1);

   localparam logic [DW-1:0]     DOT_LAST = DW'(DOT_W - 1);
   localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]     H_VIS    = HW'(H_ACTIVE);
   localparam logic [HW-1:0]     HS_ON    = HW'(H_SYNC_START);
   localparam logic [HW-1:0]     HS_OFF   = HW'(H_SYNC_START + H_SYNC_LEN);
   localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]     V_VIS    = VW'(ROWS * ROW_LINES);
   localparam logic [VW-1:0]     VS_ON    = VW'(V_SYNC_START);
   localparam logic [VW-1:0]     VS_OFF   = VW'(V_SYNC_START + V_SYNC_LEN);
   localparam logic [VW-1:0]     ROWS_V   = VW'(ROWS);
   localparam logic [VW-1:0]     TOP_V    = VW'(TOP_ROW % ROWS);
   localparam logic [3:0]        RS_LAST  = 4'(ROW_LINES - 1);
   localparam logic [RAM_AW-1:0] COL_MASK = RAM_AW'((1 << STRIDE_LOG2) - 1);
   localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

   // ---------------- raster counters ----------------
   logic [DW-1:0] dot;
   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic [VW-1:0] row;
   logic [3:0]    rs;
   logic          dot_last;
   logic          line_last;

   assign dot_last  = (dot == DOT_LAST);
   assign line_last = dot_last && (h == H_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dot <= '0;
         h   <= '0;
         v   <= '0;
         row <= '0;
         rs  <= '0;
      end else begin
         dot <= dot_last ? '0 : dot + 1'b1;
         if (dot_last)
            h <= (h == H_LAST) ? '0 : h + 1'b1;
         if (line_last) begin
            if (v == V_LAST) begin
               v   <= '0;
               rs  <= '0;
               row <= '0;
            end else begin
               v <= v + 1'b1;
               if (rs == RS_LAST) begin
                  rs  <= '0;
                  row <= row + 1'b1;
               end else begin
                  rs <= rs + 1'b1;
               end
            end
         end
      end
   end

   logic vis_v;
   logic vis;
   logic hs;
   logic vs;
   logic fs;

   assign vis_v = (v < V_VIS);
   assign vis   = (h < H_VIS) && vis_v;
   assign hs    = (h >= HS_ON) && (h < HS_OFF);
   assign vs    = (v >= VS_ON) && (v < VS_OFF);
   assign fs    = (dot == '0) && (h == '0) && (v == '0);

   // Rows below the text area still fetch; pin them to row 0 so the index stays in range.
   logic [VW-1:0]     row_sum;
   logic [VW-1:0]     ram_row;
   logic [RAM_AW-1:0] fetch_idx;

   assign row_sum = row + TOP_V;

   always_comb begin
      ram_row = row_sum;
      if (!vis_v)
         ram_row = '0;
      else if (row_sum >= ROWS_V)
         ram_row = row_sum - ROWS_V;
   end

   assign fetch_idx = (RAM_AW'(ram_row) << STRIDE_LOG2) | (RAM_AW'(h) & COL_MASK);

   // ---------------- video RAM and CPU port ----------------
   logic [7:0]        ram [DEPTH];
   logic              cpu_sel;
   logic              cpu_wr;
   logic              cpu_rd;
   logic              cpu_hit;
   logic [RAM_AW-1:0] cpu_idx;

   assign cpu_sel = !vdusel_n;
   assign cpu_wr  = cpu_sel && !wr_n;
   assign cpu_rd  = cpu_sel && !rd_n && wr_n;
   assign cpu_hit = ({1'b0, cpu_a} < DEPTH_A);
   assign cpu_idx = cpu_a[RAM_AW-1:0];

   always_ff @(posedge clk) begin
      if (cpu_wr && cpu_hit)
         ram[cpu_idx] <= cpu_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cpu_dout <= '0;
      else if (cpu_rd)
         cpu_dout <= cpu_hit ? ram[cpu_idx] : 8'hFF;
   end

   // ---------------- fetch and dot pipeline ----------------
   logic inv_bit;

`ifdef NAS_VID_GEN_INVERSE_EN
   assign inv_bit = ram[fetch_idx][7];
`else
   assign inv_bit = 1'b0;
`endif

   logic             ld1;
   logic             ld2;
   logic             blank1;
   logic             blank2;
   logic             inv1;
   logic             inv2;
   logic             blank_char;
   logic [DOT_W-1:0] shift;
   logic [2:0]       vis_p;
   logic [2:0]       hs_p;
   logic [2:0]       vs_p;
   logic [2:0]       fs_p;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chr_code   <= '0;
         chr_rs     <= '0;
         ld1        <= 1'b0;
         ld2        <= 1'b0;
         blank1     <= 1'b0;
         blank2     <= 1'b0;
         inv1       <= 1'b0;
         inv2       <= 1'b0;
         blank_char <= 1'b0;
         shift      <= '0;
         vis_p      <= '0;
         hs_p       <= '0;
         vs_p       <= '0;
         fs_p       <= '0;
      end else begin
         ld1   <= (dot == '0);
         ld2   <= ld1;
         vis_p <= {vis_p[1:0], vis};
         hs_p  <= {hs_p[1:0], hs};
         vs_p  <= {vs_p[1:0], vs};
         fs_p  <= {fs_p[1:0], fs};
         // Any CPU select in the fetch cycle blanks the whole character (CPU has priority).
         if (dot == '0) begin
            chr_code <= ram[fetch_idx][6:0];
            chr_rs   <= rs;
            blank1   <= cpu_sel;
            inv1     <= inv_bit;
         end
         if (ld1) begin
            blank2 <= blank1;
            inv2   <= inv1;
         end
         if (ld2) begin
            shift      <= chr_dots ^ {DOT_W{inv2}};
            blank_char <= blank2;
         end else begin
            shift <= {shift[DOT_W-2:0], 1'b0};
         end
      end
   end

   assign vid_data    = shift[DOT_W-1] & vis_p[2] & ~blank_char;
   assign vid_active  = vis_p[2];
   assign vid_sync    = ~(hs_p[2] | vs_p[2]);
   assign frame_start = fs_p[2];

endmodule

`default_nettype wire

// File: tb/tb_nas_vid_gen.sv
// ============================================================================
// tb_nas_vid_gen - directed self-checking bench for nas_vid_gen.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_nas_vid_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       vdusel_n = 1'b1;
   logic       wr_n = 1'b1;
   logic       rd_n = 1'b1;
   logic [9:0] cpu_a = '0;
   logic [7:0] cpu_din = '0;
   logic [7:0] cpu_dout;
   logic [6:0] chr_code;
   logic [3:0] chr_rs;
   logic [7:0] chr_dots = '0;
   logic       vid_sync;
   logic       vid_data;
   logic       vid_active;
   logic       frame_start;

   // small-frame instance for frame period and address-range checks
   logic       rst_s = 1'b0;
   logic       s_vdusel_n = 1'b1;
   logic       s_wr_n = 1'b1;
   logic       s_rd_n = 1'b1;
   logic [7:0] s_cpu_a = '0;
   logic [7:0] s_cpu_din = '0;
   logic [7:0] s_cpu_dout;
   logic [6:0] s_chr_code;
   logic [3:0] s_chr_rs;
   logic [7:0] s_chr_dots = 8'h00;
   logic       s_vid_sync;
   logic       s_vid_data;
   logic       s_vid_active;
   logic       s_frame_start;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   nas_vid_gen u_dut (
      .clk(clk), .rst(rst), .vdusel_n(vdusel_n), .wr_n(wr_n), .rd_n(rd_n),
      .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
      .chr_code(chr_code), .chr_rs(chr_rs), .chr_dots(chr_dots),
      .vid_sync(vid_sync), .vid_data(vid_data), .vid_active(vid_active),
      .frame_start(frame_start)
   );

   nas_vid_gen #(
      .ROW_LINES(4), .ROWS(2), .V_TOTAL(12), .V_SYNC_START(9), .V_SYNC_LEN(2),
      .TOP_ROW(1), .ADDR_W(8)
   ) u_small (
      .clk(clk), .rst(rst_s), .vdusel_n(s_vdusel_n), .wr_n(s_wr_n), .rd_n(s_rd_n),
      .cpu_a(s_cpu_a), .cpu_din(s_cpu_din), .cpu_dout(s_cpu_dout),
      .chr_code(s_chr_code), .chr_rs(s_chr_rs), .chr_dots(s_chr_dots),
      .vid_sync(s_vid_sync), .vid_data(s_vid_data), .vid_active(s_vid_active),
      .frame_start(s_frame_start)
   );

   // character ROM model: one clk latency
   function automatic logic [7:0] rom(input logic [6:0] code);
      case (code)
         7'h41:   rom = 8'hAA;
         7'h7F:   rom = 8'hFF;
         default: rom = 8'h00;
      endcase
   endfunction

   always @(posedge clk) chr_dots <= rom(chr_code);

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic start_frame();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
      cpu_a = a; cpu_din = d; vdusel_n = 1'b0; wr_n = 1'b0;
      step();
      vdusel_n = 1'b1; wr_n = 1'b1;
   endtask

   task automatic cpu_read(input logic [9:0] a);
      cpu_a = a; vdusel_n = 1'b0; rd_n = 1'b0;
      step();
      vdusel_n = 1'b1; rd_n = 1'b1;
   endtask

   task automatic s_write(input logic [7:0] a, input logic [7:0] d);
      s_cpu_a = a; s_cpu_din = d; s_vdusel_n = 1'b0; s_wr_n = 1'b0;
      step();
      s_vdusel_n = 1'b1; s_wr_n = 1'b1;
   endtask

   task automatic s_read(input logic [7:0] a);
      s_cpu_a = a; s_vdusel_n = 1'b0; s_rd_n = 1'b0;
      step();
      s_vdusel_n = 1'b1; s_rd_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      rst = 1'b1; rst_s = 1'b1;
      #1;
      checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL reset_cpu_dout: got %h expected 00", cpu_dout); end
      checks++; if (chr_code !== 7'h00) begin errors++; $display("FAIL reset_chr_code: got %h expected 00", chr_code); end
      checks++; if (chr_rs !== 4'h0) begin errors++; $display("FAIL reset_chr_rs: got %h expected 0", chr_rs); end
      checks++; if (vid_data !== 1'b0) begin errors++; $display("FAIL reset_vid_data: got %b expected 0", vid_data); end
      checks++; if (vid_active !== 1'b0) begin errors++; $display("FAIL reset_vid_active: got %b expected 0", vid_active); end
      checks++; if (vid_sync !== 1'b1) begin errors++; $display("FAIL reset_vid_sync: got %b expected 1", vid_sync); end
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
      @(posedge clk);
      #1;
      rst = 1'b0; rst_s = 1'b0;
      cyc = 0;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (frame_start !== (k == 3)) begin
            errors++;
            $display("FAIL reset_release_fs edge %0d: got %b expected %b", k, frame_start, (k == 3));
         end
      end
   endtask

   task automatic test_cpu_rw();
      cpu_write(10'h005, 8'h5A);
      cpu_read(10'h005);
      checks++; if (cpu_dout !== 8'h5A) begin errors++; $display("FAIL cpu_read_005: got %h expected 5a", cpu_dout); end
      cpu_a = 10'h3FF; rd_n = 1'b0; vdusel_n = 1'b1;
      step();
      rd_n = 1'b1;
      checks++; if (cpu_dout !== 8'h5A) begin errors++; $display("FAIL cpu_read_unselected_hold: got %h expected 5a", cpu_dout); end
      rd_n = 1'b0;
      cpu_write(10'h3FF, 8'h00);
      rd_n = 1'b1;
      checks++; if (cpu_dout !== 8'h5A) begin errors++; $display("FAIL cpu_write_wins_hold: got %h expected 5a", cpu_dout); end
      cpu_read(10'h3FF);
      checks++; if (cpu_dout !== 8'h00) begin errors++; $display("FAIL cpu_read_3ff: got %h expected 00", cpu_dout); end
   endtask

   task automatic test_out_of_range();
      s_write(8'h00, 8'h33);
      s_write(8'h7F, 8'hC3);
      s_write(8'h80, 8'h77);
      s_read(8'h80);
      checks++; if (s_cpu_dout !== 8'hFF) begin errors++; $display("FAIL oob_read_80: got %h expected ff", s_cpu_dout); end
      s_read(8'h00);
      checks++; if (s_cpu_dout !== 8'h33) begin errors++; $display("FAIL oob_write_ignored: got %h expected 33", s_cpu_dout); end
      s_read(8'h7F);
      checks++; if (s_cpu_dout !== 8'hC3) begin errors++; $display("FAIL top_addr_read_7f: got %h expected c3", s_cpu_dout); end
   endtask

   task automatic load_screen();
      cpu_write(10'h3C0, 8'h41);
      cpu_write(10'h3C1, 8'h00);
      cpu_write(10'h3C2, 8'hC1);
      cpu_write(10'h3C8, 8'h00);
      cpu_write(10'h3C9, 8'h7F);
      cpu_write(10'h3CA, 8'h7F);
      cpu_write(10'h3CB, 8'h7F);
      cpu_write(10'h3CC, 8'h00);
   endtask

   task automatic test_glyph();
      logic [7:0] exp;
      exp = 8'hAA;
      start_frame();
      step_to(1);
      checks++; if (chr_code !== 7'h41) begin errors++; $display("FAIL glyph_chr_code: got %h expected 41", chr_code); end
      checks++; if (chr_rs !== 4'h0) begin errors++; $display("FAIL glyph_chr_rs: got %h expected 0", chr_rs); end
      for (int i = 0; i < 8; i++) begin
         step_to(3 + i);
         checks++;
         if (vid_data !== exp[7-i]) begin
            errors++;
            $display("FAIL glyph_dot %0d: got %b expected %b", i, vid_data, exp[7-i]);
         end
      end
   endtask

   task automatic test_inverse();
      logic [7:0] exp;
`ifdef NAS_VID_GEN_INVERSE_EN
      exp = 8'h55;
`else
      exp = 8'hAA;
`endif
      start_frame();
      step_to(17);
      checks++; if (chr_code !== 7'h41) begin errors++; $display("FAIL inverse_chr_code: got %h expected 41", chr_code); end
      for (int i = 0; i < 8; i++) begin
         step_to(19 + i);
         checks++;
         if (vid_data !== exp[7-i]) begin
            errors++;
            $display("FAIL inverse_dot %0d: got %b expected %b", i, vid_data, exp[7-i]);
         end
      end
   endtask

   task automatic test_contention();
      logic exp;
      start_frame();
      for (int k = 75; k <= 98; k++) begin
         step_to(k);
         exp = !(k >= 83 && k <= 90);
         checks++;
         if (vid_data !== exp) begin
            errors++;
            $display("FAIL contention_edge %0d: got %b expected %b", k, vid_data, exp);
         end
         if (k == 80) vdusel_n = 1'b0;
         if (k == 81) vdusel_n = 1'b1;
      end
   endtask

   task automatic test_line_timing();
      int n_act;
      int n_low;
      int first_low;
      logic act_386;
      logic act_387;
      n_act = 0; n_low = 0; first_low = -1; act_386 = 1'b0; act_387 = 1'b1;
      start_frame();
      for (int k = 3; k <= 514; k++) begin
         step_to(k);
         if (vid_active) n_act++;
         if (!vid_sync) begin
            n_low++;
            if (first_low < 0) first_low = k;
         end
         if (k == 386) act_386 = vid_active;
         if (k == 387) act_387 = vid_active;
      end
      checks++; if (n_act != 384) begin errors++; $display("FAIL line_active_count: got %0d expected 384", n_act); end
      checks++; if (n_low != 40) begin errors++; $display("FAIL line_hsync_count: got %0d expected 40", n_low); end
      checks++; if (first_low != 419) begin errors++; $display("FAIL line_hsync_start: got %0d expected 419", first_low); end
      checks++; if (act_386 !== 1'b1) begin errors++; $display("FAIL line_last_active: got %b expected 1", act_386); end
      checks++; if (act_387 !== 1'b0) begin errors++; $display("FAIL line_first_inactive: got %b expected 0", act_387); end
   endtask

   task automatic test_frame();
      int first_fs;
      int second_fs;
      int n_fs;
      int n_act;
      int n_low;
      first_fs = -1; second_fs = -1; n_fs = 0; n_act = 0; n_low = 0;
      @(posedge clk);
      #1;
      rst_s = 1'b1;
      @(posedge clk);
      #1;
      rst_s = 1'b0;
      for (int k = 1; k <= 6150; k++) begin
         @(posedge clk);
         #1;
         if (s_frame_start) begin
            n_fs++;
            if (first_fs < 0) first_fs = k;
            else if (second_fs < 0) second_fs = k;
         end
         if (k >= 3 && k <= 6146) begin
            if (s_vid_active) n_act++;
            if (!s_vid_sync) n_low++;
         end
      end
      checks++; if (first_fs != 3) begin errors++; $display("FAIL frame_first_fs: got %0d expected 3", first_fs); end
      checks++; if (second_fs - first_fs != 6144) begin errors++; $display("FAIL frame_period: got %0d expected 6144", second_fs - first_fs); end
      checks++; if (n_fs != 2) begin errors++; $display("FAIL frame_fs_pulses: got %0d expected 2", n_fs); end
      checks++; if (n_act != 3072) begin errors++; $display("FAIL frame_active_count: got %0d expected 3072", n_act); end
      checks++; if (n_low != 1424) begin errors++; $display("FAIL frame_sync_low_count: got %0d expected 1424", n_low); end
   endtask

   task automatic test_async_reset();
      start_frame();
      step_to(51363);
      checks++; if (vid_active !== 1'b1) begin errors++; $display("FAIL midframe_active: got %b expected 1", vid_active); end
      checks++; if (chr_rs !== 4'h4) begin errors++; $display("FAIL midframe_chr_rs: got %h expected 4", chr_rs); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (vid_active !== 1'b0) begin errors++; $display("FAIL async_vid_active: got %b expected 0", vid_active); end
      checks++; if (chr_rs !== 4'h0) begin errors++; $display("FAIL async_chr_rs: got %h expected 0", chr_rs); end
      checks++; if (vid_data !== 1'b0) begin errors++; $display("FAIL async_vid_data: got %b expected 0", vid_data); end
      checks++; if (vid_sync !== 1'b1) begin errors++; $display("FAIL async_vid_sync: got %b expected 1", vid_sync); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (frame_start !== (k == 3)) begin
            errors++;
            $display("FAIL async_release_fs edge %0d: got %b expected %b", k, frame_start, (k == 3));
         end
      end
   endtask

   initial begin
      test_reset();
      test_cpu_rw();
      test_out_of_range();
      load_screen();
      test_glyph();
      test_inverse();
      test_contention();
      test_line_timing();
      test_frame();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nas_vid_gen.md
Name: nas_vid_gen

Overview:
- Parametrised, fully synchronous successor to the NASCOM 1 discrete video circuit.
- Generates composite-video timing and the dot stream for a memory-mapped character display.
- Contains the video RAM and a CPU access port; fetches the glyph from an external character-generator ROM.
- Defaults reproduce the NASCOM 1 raster: 48 visible columns, 64-byte row stride, 16 rows, 16 scanlines per row, top displayed row = 15. Other settings cover NASCOM 2 style formats.

Parameters:
- DOT_W, 8: dots per character cell; bit DOT_W-1 of each glyph is shifted out first.
- H_TOTAL, 64: character times per scanline.
- H_ACTIVE, 48: visible characters per scanline, starting at character time 0.
- H_SYNC_START, 52: character time at which hsync asserts.
- H_SYNC_LEN, 5: hsync width in character times.
- ROW_LINES, 16: scanlines per text row; must be 2..16.
- ROWS, 16: visible text rows.
- V_TOTAL, 312: scanlines per frame.
- V_SYNC_START, 290: scanline at which vsync asserts.
- V_SYNC_LEN, 10: vsync width in scanlines.
- STRIDE_LOG2, 6: RAM row stride is 2^STRIDE_LOG2 bytes; must satisfy 2^STRIDE_LOG2 >= H_ACTIVE.
- TOP_ROW, 15: RAM row displayed on screen row 0; later screen rows wrap modulo ROWS.
- ADDR_W, 10: CPU/RAM address width; RAM depth is ROWS<<STRIDE_LOG2 and must be <= 2^ADDR_W.

Ports:
- clk, in, 1: dot clock; one dot per cycle (16 MHz in system).
- rst, in, 1: asynchronous, active-high reset.
- vdusel_n, in, 1: CPU selects video RAM, active low.
- wr_n, in, 1: CPU write strobe, active low.
- rd_n, in, 1: CPU read strobe, active low.
- cpu_a, in, ADDR_W: CPU address.
- cpu_din, in, 8: CPU write data.
- cpu_dout, out, 8: CPU read data, registered.
- chr_code, out, 7: glyph code to character ROM.
- chr_rs, out, 4: scanline within the glyph.
- chr_dots, in, DOT_W: ROM dot row; valid one clk after chr_code/chr_rs.
- vid_sync, out, 1: composite sync, low during hsync OR vsync.
- vid_data, out, 1: dot output, 1 = white.
- vid_active, out, 1: pixel is within the visible window.
- frame_start, out, 1: one-clk pulse at dot 0, char 0, scanline 0.

Behaviour:
- Reset values: all counters 0, cpu_dout 0, chr_code 0, chr_rs 0, vid_data 0, vid_active 0, vid_sync 1, frame_start 0, shift register 0.
- Counters: dot 0..DOT_W-1, char h 0..H_TOTAL-1, scanline v 0..V_TOTAL-1. Each wraps to 0; a carry advances the next counter. All counters wrap together at frame end.
- Text row = v / ROW_LINES. chr_rs = v mod ROW_LINES.
- Visible window: h < H_ACTIVE and v < ROWS*ROW_LINES.
- RAM address = (((row+TOP_ROW) mod ROWS) << STRIDE_LOG2) | h.
- Fetch pipeline, for dot 0 of char h:
  - Cycle 0: RAM read issued.
  - Cycle 1: chr_code/chr_rs registered.
  - Cycle 2: chr_dots sampled.
  - Cycle 3: loaded into the shift register.
- Pipeline latency is 3 clk. hsync, vsync, visible and frame_start are each delayed 3 clk to stay aligned with the dots.
- vid_data = shift MSB AND delayed-visible AND NOT blank_char.
- CPU port:
  - Write: wr_n=0 and vdusel_n=0 writes cpu_din to cpu_a every clk the condition holds.
  - Read: rd_n=0 and vdusel_n=0 updates cpu_dout the next clk; otherwise cpu_dout holds.
  - wr_n and rd_n both low: write wins, cpu_dout holds.
  - Addresses >= RAM depth: writes ignored, reads return 0xFF.
- Contention (NASCOM semantics): the CPU always has priority. If vdusel_n=0 during a character's fetch cycle, blank_char is set for that whole character and vid_data = 0. The display fetch never stalls the CPU.
- Glyph code is RAM data bits 6:0. Bit 7 is ignored unless the optional feature is enabled.
- Async rst mid-frame: everything returns to the reset values immediately. On release, the first frame_start occurs 3 clk after the first rising edge.

Optional Feature:
- Macro: NAS_VID_GEN_INVERSE_EN.
- Defined: a RAM bit 7 of 1 inverts the character's DOT_W dots (inverse video). It applies only inside the visible window and not to blanked characters.
- Undefined: bit 7 has no effect on the display; CPU readback of bit 7 is unchanged in both builds.

Test Plan:
- Reset then free-run with defaults: frame_start period = 8*64*312 = 159744 clk; hsync low for 40 clk starting at clk 416 of each line (before pipeline delay); vid_active high 384 clk per line on lines 0..255.
- CPU write 0x41 to address 0x3C0 (row 15, col 0), ROM model returns 0xAA: chr_code = 0x41 and chr_rs = 0 at screen line 0, char 0; dots 1,0,1,0,1,0,1,0 appear starting 3 clk after line start.
- Write 0x5A to address 0x005, then read it back: cpu_dout = 0x5A one clk after rd_n falls; read of 0x3FF after reset-free write of 0x00 returns 0x00.
- Hold vdusel_n low during char 10 fetch on a visible line: vid_data = 0 for all 8 dots of char 10; chars 9 and 11 unaffected.
- Assert rst at line 100 mid-char: outputs reach reset values without a clock edge; release gives frame_start 3 clk after the first edge.
- With NAS_VID_GEN_INVERSE_EN: write 0xC1, ROM 0xAA -> dots 0,1,0,1,0,1,0,1. Without the macro -> 1,0,1,0,1,0,1,0.
